cpu_scoreboard_regfile: RTL and testbench

- Parametrised general-purpose register file with an integrated scoreboard for the in-order CPU pipeline.
- It sits between decode/issue and writeback. It provides READ_PORTS source reads, one writeback port, and per-register pending-write counters instead of single lock bits.
- It supports multiple outstanding writes to one register, writeback-to-issue bypass, and a flush that clears all pending state.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_pend_counter.sv | 31 +++
 rtl/cpu_scoreboard_regfile.sv | 120 ++++++++++++
 tb/tb_cpu_scoreboard_regfile.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared defaults and helpers for the CPU register-file / scoreboard slice.
// The source-index helper works on a zero-extended copy of the packed vector.
package cpu_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int REG_COUNT_DEF = 32;
    localparam int ADDR_W_DEF    = $clog2(REG_COUNT_DEF);
    localparam int SRC_VEC_MAX   = 64;

    function automatic logic [31:0] src_index(
        input logic [SRC_VEC_MAX-1:0] vec,
        input int unsigned            k,
        input int unsigned            addr_w
    );
        logic [SRC_VEC_MAX-1:0] shifted;
        shifted = (vec >> (k * addr_w)) & ((SRC_VEC_MAX'(1) << addr_w) - SRC_VEC_MAX'(1));
        return 32'(shifted);
    endfunction

endpackage

// File: rtl/cpu_pend_counter.sv
// Per-register pending-write counter: saturating, underflow-safe, with clear.
// Simultaneous inc and dec leave the count unchanged.
module cpu_pend_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] count,
    output logic              is_zero,
    output logic              is_one,
    output logic              is_max
);

    assign is_zero = (count == '0);
    assign is_one  = (count == PEND_W'(1));
    assign is_max  = (count == '1);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !dec && !is_max) begin
            count <= count + PEND_W'(1);
        end else if (dec && !inc && !is_zero) begin
            count <= count - PEND_W'(1);
        end
    end

endmodule

// File: rtl/cpu_scoreboard_regfile.sv
// Register file with counting scoreboard, writeback-to-issue bypass and flush.
// Register 0 reads as zero, is never written and never has pending writes.
module cpu_scoreboard_regfile
    import cpu_pkg::*;
#(
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  REG_COUNT  = REG_COUNT_DEF,
    parameter int  READ_PORTS = 2,
    parameter int  PEND_W     = 2,
    localparam int ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iss_valid,
    input  logic [READ_PORTS*ADDR_W-1:0] iss_src,
    input  logic [ADDR_W-1:0]            iss_dst,
    input  logic                         iss_dst_en,
    output logic                         iss_ready,
    output logic                         src_valid,
    output logic [READ_PORTS*DATA_W-1:0] src_data,
    input  logic                         wb_valid,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         flush,
    output logic [31:0]                  stall_count
);

    logic [PEND_W-1:0]            pend_cnt [REG_COUNT];
    logic [REG_COUNT-1:0]         pend_zero;
    logic [REG_COUNT-1:0]         pend_one;
    logic [REG_COUNT-1:0]         pend_max;
    logic [DATA_W-1:0]            regs [REG_COUNT];
    logic [ADDR_W-1:0]            src [READ_PORTS];
    logic [READ_PORTS*DATA_W-1:0] rd_data;
    logic                         we;
    logic                         bypass;
    logic                         src_hazard;
    logic                         dst_hazard;
    logic                         accept;

    assign we = wb_valid && (wb_addr != '0);

    assign pend_cnt[0]  = '0;
    assign pend_zero[0] = 1'b1;
    assign pend_one[0]  = 1'b0;
    assign pend_max[0]  = 1'b0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_pend
        logic inc;
        logic dec;

        assign inc = accept && iss_dst_en && (iss_dst == ADDR_W'(r));
        assign dec = we && (wb_addr == ADDR_W'(r));

        cpu_pend_counter #(.PEND_W(PEND_W)) u_pend (
            .clock   (clock),
            .reset   (reset),
            .inc     (inc),
            .dec     (dec),
            .clr     (flush),
            .count   (pend_cnt[r]),
            .is_zero (pend_zero[r]),
            .is_one  (pend_one[r]),
            .is_max  (pend_max[r])
        );
    end

    always_comb begin
        for (int k = 0; k < READ_PORTS; k++) begin
            src[k] = ADDR_W'(src_index(SRC_VEC_MAX'(iss_src), k, ADDR_W));
        end
    end

    // A single pending write is fine when it retires this very cycle.
    always_comb begin
        src_hazard = 1'b0;
        bypass     = 1'b0;
        rd_data    = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            bypass = we && (wb_addr == src[k]);
            if (!pend_zero[src[k]] &&
                ((pend_cnt[src[k]] > PEND_W'(1)) || (pend_one[src[k]] && !bypass))) begin
                src_hazard = 1'b1;
            end
            if (bypass) begin
                rd_data[k*DATA_W +: DATA_W] = wb_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[src[k]];
            end
        end
    end

    assign dst_hazard = iss_dst_en && (iss_dst != '0) && pend_max[iss_dst] &&
                        !(we && (wb_addr == iss_dst));
    assign iss_ready  = !flush && !src_hazard && !dst_hazard;
    assign accept     = iss_valid && iss_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            src_valid   <= 1'b0;
            src_data    <= '0;
            stall_count <= '0;
            for (int r = 0; r < REG_COUNT; r++) begin
                regs[r] <= '0;
            end
        end else begin
            src_valid <= accept;
            if (accept) begin
                src_data <= rd_data;
            end
            if (iss_valid && !iss_ready && !flush && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (we) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_scoreboard_regfile.sv
// Bench for cpu_scoreboard_regfile: directed scenarios then random traffic,
// all cycles compared against an array-based reference model.
module tb_cpu_scoreboard_regfile;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int RP = 2;
    localparam int AW = 5;
    localparam int PMAX = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             iss_valid;
    logic [RP*AW-1:0] iss_src;
    logic [AW-1:0]    iss_dst;
    logic             iss_dst_en;
    logic             iss_ready;
    logic             src_valid;
    logic [RP*DW-1:0] src_data;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic             flush;
    logic [31:0]      stall_count;

    cpu_scoreboard_regfile dut (
        .clock       (clock),
        .reset       (reset),
        .iss_valid   (iss_valid),
        .iss_src     (iss_src),
        .iss_dst     (iss_dst),
        .iss_dst_en  (iss_dst_en),
        .iss_ready   (iss_ready),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    m_regs [RC];
    int               m_pend [RC];
    logic [31:0]      m_stall;
    logic             m_valid;
    logic [RP*DW-1:0] m_data;
    logic             obs_ready;
    logic [31:0]      saved_stall;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready();
        logic we;
        we = wb_valid && (wb_addr != 0);
        if (flush) return 1'b0;
        for (int k = 0; k < RP; k++) begin
            logic [AW-1:0] s;
            s = iss_src[k*AW +: AW];
            if (m_pend[s] > 1) return 1'b0;
            if (m_pend[s] == 1 && !(we && wb_addr == s)) return 1'b0;
        end
        if (iss_dst_en && iss_dst != 0 && m_pend[iss_dst] == PMAX && !(we && wb_addr == iss_dst))
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input logic v, input int s0, input int s1, input int dst, input logic en,
                         input logic wv, input int wa, input logic [31:0] wd,
                         input logic fl, input logic rs);
        iss_valid  = v;
        iss_src    = {AW'(s1), AW'(s0)};
        iss_dst    = AW'(dst);
        iss_dst_en = en;
        wb_valid   = wv;
        wb_addr    = AW'(wa);
        wb_data    = wd;
        flush      = fl;
        reset      = rs;
    endtask

    task automatic cycle();
        logic rdy;
        logic we;
        logic acc;
        #1;
        rdy = model_ready();
        obs_ready = iss_ready;
        check_val("iss_ready", iss_ready, rdy);
        we  = wb_valid && (wb_addr != 0);
        acc = iss_valid && rdy;
        if (reset) begin
            for (int r = 0; r < RC; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 0;
            end
            m_valid = 1'b0;
            m_data  = '0;
            m_stall = '0;
        end else begin
            m_valid = acc;
            if (acc) begin
                for (int k = 0; k < RP; k++) begin
                    logic [AW-1:0] s;
                    s = iss_src[k*AW +: AW];
                    if (s == 0)                    m_data[k*DW +: DW] = '0;
                    else if (we && wb_addr == s)   m_data[k*DW +: DW] = wb_data;
                    else                           m_data[k*DW +: DW] = m_regs[s];
                end
            end
            if (iss_valid && !rdy && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (flush) begin
                for (int r = 0; r < RC; r++) m_pend[r] = 0;
            end else begin
                if (acc && iss_dst_en && iss_dst != 0) m_pend[iss_dst] = m_pend[iss_dst] + 1;
                if (we && m_pend[wb_addr] > 0) m_pend[wb_addr] = m_pend[wb_addr] - 1;
            end
            if (we) m_regs[wb_addr] = wb_data;
        end
        @(posedge clock);
        #1;
        check_val("src_valid", src_valid, m_valid);
        check_val("src_data", src_data, m_data);
        check_val("stall_count", stall_count, m_stall);
        @(negedge clock);
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, RC - 1));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        cycle();
        check_val("rst_src_valid", src_valid, 0);
        check_val("rst_stall", stall_count, 0);

        // Basic read of zeroed registers, dst=0 leaves counters alone
        drive(1, 3, 5, 0, 1, 0, 0, 0, 0, 0);
        cycle();
        check_val("basic_ready", obs_ready, 1);
        check_val("basic_data", src_data, 64'h0);

        // RAW stall on r3, then bypass release
        drive(0, 0, 0, 0, 0, 1, 3, 32'hDEAD, 0, 0);
        cycle();
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("raw_stall", obs_ready, 0);
        cycle();
        check_val("raw_stall_cnt", stall_count, 2);
        drive(1, 3, 0, 0, 0, 1, 3, 32'hBEEF, 0, 0);
        cycle();
        check_val("bypass_ready", obs_ready, 1);
        check_val("bypass_data", src_data, {32'h0, 32'hBEEF});
        drive(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("r3_pend_clear", obs_ready, 1);

        // Counter saturation on r7
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
            cycle();
        end
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        cycle();
        check_val("dst_full", obs_ready, 0);
        drive(1, 0, 0, 7, 1, 1, 7, 32'h77, 0, 0);
        cycle();
        check_val("dst_full_wb", obs_ready, 1);
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("r7_still_full", obs_ready, 0);

        // Two pending writes on r9
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(1, 9, 0, 0, 0, 1, 9, 32'h1, 0, 0);
        cycle();
        check_val("r9_two_pend", obs_ready, 0);
        drive(1, 9, 0, 0, 0, 1, 9, 32'h2, 0, 0);
        cycle();
        check_val("r9_last_wb", obs_ready, 1);
        check_val("r9_data", src_data, {32'h0, 32'h2});

        // Flush with concurrent issue and writeback
        drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        saved_stall = stall_count;
        drive(1, 4, 0, 0, 0, 1, 4, 32'h55, 1, 0);
        cycle();
        check_val("flush_ready", obs_ready, 0);
        check_val("flush_valid", src_valid, 0);
        check_val("flush_stall", stall_count, saved_stall);
        drive(1, 4, 7, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("post_flush_ready", obs_ready, 1);
        check_val("post_flush_data", src_data, {32'h77, 32'h55});

        // Writes to r0 are dropped
        drive(0, 0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("r0_data", src_data, 64'h0);

        // Reset in the middle of a stall
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("r5_stall", obs_ready, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check_val("mid_rst_valid", src_valid, 0);
        check_val("mid_rst_stall", stall_count, 0);
        check_val("mid_rst_data", src_data, 64'h0);
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_val("mid_rst_pend", obs_ready, 1);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_addr(), rnd_addr(), rnd_addr(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
